bvurem_inv_search: RTL
======================

# bvurem_inv_search

Parametrised sequential invertibility solver for unsigned-remainder constraints. Given bit-vectors `s` and `t` of width `WIDTH`, it searches for the smallest `x` such that `(x urem s) REL t` or `(s urem x) REL t`. REL is selectable among signed and unsigned less-than and less-or-equal. It is the multi-width, multi-relation, multi-operand-position successor to the fixed 4-bit combinational Skolem functions. It sits behind the constraint front end on a valid/ready handshake.

## Interface
- `WIDTH`, default 4: bit width of `s`, `t`, `x`; legal range 2..16.
- `clk` input, 1 bit: single clock; all state updates on the rising edge.
- `rst_n` input, 1 bit: asynchronous, active-low reset.
- `in_valid` input, 1 bit: request present.
- `in_ready` output, 1 bit: block can accept a request; high only in IDLE.
- `in_s` input, `WIDTH` bits: operand `s`.
- `in_t` input, `WIDTH` bits: bound `t`.
- `in_rel` input, 2 bits: relation; 0 = sle, 1 = slt, 2 = ule, 3 = ult.
- `in_pos` input, 1 bit: 0 = constraint `(x urem s) REL t`; 1 = constraint `(s urem x) REL t`.
- `out_valid` output, 1 bit: result available.
- `out_ready` input, 1 bit: consumer accepts the result.
- `out_found` output, 1 bit: a satisfying `x` exists.
- `out_x` output, `WIDTH` bits: smallest satisfying `x`; 0 when not found.
- `out_rem` output, `WIDTH` bits: remainder for `out_x`; 0 when not found.

## Operation
- States:
  - IDLE: `in_ready`=1.
  - LOAD, DIV, CMP: per-candidate evaluation.
  - DONE: `out_valid`=1.
- IDLE→LOAD on `in_valid & in_ready`. `s`, `t`, `rel`, `pos` are registered. The candidate counter is cleared to 0.
- LOAD (1 cycle):
  - Set dividend and divisor from `pos`: `pos`=0 gives dividend=`x`, divisor=`s`; `pos`=1 gives dividend=`s`, divisor=`x`.
  - Clear the partial remainder.
  - Go to DIV.
- DIV (`WIDTH`-1 cycles plus 1 final step, `WIDTH` cycles total):
  - Restoring division, one quotient bit per cycle, MSB first.
  - After the last step go to CMP.
- CMP is folded into the last DIV cycle. The result is registered at the edge ending that cycle.
- Divisor zero: the remainder is the dividend (SMT-LIB semantics). The divider still runs its full `WIDTH` cycles; the result is overridden to the dividend.
- Comparison:
  - Signed relations treat the remainder and `t` as two's complement `WIDTH`-bit values.
  - Unsigned relations treat them as plain binary.
- If the comparison is satisfied: latch `out_found`=1, `out_x`=candidate, `out_rem`=remainder; go to DONE.
- Else, if candidate = 2^`WIDTH`-1: latch `out_found`=0, `out_x`=0, `out_rem`=0; go to DONE.
- Else: increment the candidate and go to LOAD. The counter is `WIDTH`+1 bits so the terminal check does not wrap.
- DONE: hold all outputs stable while `out_ready`=0. On `out_valid & out_ready` go to IDLE.
- Inputs are ignored outside IDLE. `in_s` and `in_t` may change freely after acceptance.

## Timing
- Reset values: `in_ready`=1, `out_valid`=0, `out_found`=0, `out_x`=0, `out_rem`=0; state IDLE. Reset takes effect immediately (asynchronous).
- Each candidate costs exactly `WIDTH`+1 cycles.
- Acceptance edge E0, success at candidate k: `out_valid` rises at edge E0 + (k+1)(`WIDTH`+1).
- No solution: `out_valid` rises at edge E0 + 2^`WIDTH`·(`WIDTH`+1).
- `in_ready` falls at the edge after E0 and rises at the edge after the output handshake. There is no back-to-back acceptance in the same cycle as the output handshake.
- `rst_n` low mid-search aborts immediately. There is no partial result and no `out_valid` glitch. After release the block is in IDLE.
- Minimum one idle cycle between requests.

## Test plan
- `WIDTH`=4, s=0, t=4'b1111, rel=sle, pos=0 → `out_found`=1, `out_x`=8, `out_rem`=8; `out_valid` 45 cycles after acceptance.
- s=3, t=4'b1111, rel=sle, pos=0 (remainder never negative) → `out_found`=0, `out_x`=0, `out_rem`=0; `out_valid` 80 cycles after acceptance.
- s=7, t=1, rel=ult, pos=1 → x=0 is rejected (7 urem 0 = 7); `out_found`=1, `out_x`=1, `out_rem`=0 at 10 cycles.
- s=5, t=0, rel=ult, pos=0 → unsatisfiable; `out_found`=0 after 80 cycles. `in_valid` pulses during the search are ignored and `in_ready` stays 0.
- Backpressure on s=6, t=2, rel=ule, pos=0 (result x=0, rem=0 at 5 cycles): hold `out_ready`=0 for 3 cycles → outputs are stable and `in_ready`=0. Release → IDLE next edge.
- Assert `rst_n`=0 at cycle 20 of the s=3/t=4'b1111 search → outputs go to reset values asynchronously. A new request after release returns the correct fresh result.

Source files
------------

// File: rtl/bvurem_inv_search.sv
// Sequential invertibility solver for unsigned-remainder constraints.
// Finds the smallest x such that (x urem s) REL t (pos=0) or (s urem x) REL t (pos=1).
// Each candidate takes one LOAD cycle and WIDTH restoring-division cycles.
// The relation compare is folded into the last division step.
module bvurem_inv_search #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_s,
    input  logic [WIDTH-1:0] in_t,
    input  logic [1:0]       in_rel,
    input  logic             in_pos,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_found,
    output logic [WIDTH-1:0] out_x,
    output logic [WIDTH-1:0] out_rem
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0]  LAST_STEP = CW'(WIDTH - 1);
    localparam logic [WIDTH:0] LAST_CAND = {1'b0, {WIDTH{1'b1}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_DIV,
        S_DONE
    } state_e;

    typedef enum logic [1:0] {
        REL_SLE = 2'd0,
        REL_SLT = 2'd1,
        REL_ULE = 2'd2,
        REL_ULT = 2'd3
    } rel_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic [WIDTH-1:0] t_q, t_d;
    rel_e             rel_q, rel_d;
    logic             pos_q, pos_d;
    // One bit wider than x so the terminal candidate never wraps to zero.
    logic [WIDTH:0]   cand_q, cand_d;
    // Dividend shifts left each step; the quotient bits fill in from the LSB.
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [CW-1:0]    step_q, step_d;
    logic             found_q, found_d;
    logic [WIDTH-1:0] x_q, x_d;
    logic [WIDTH-1:0] res_rem_q, res_rem_d;

    logic [WIDTH:0]   trial;
    logic [WIDTH:0]   dvs_ext;
    logic [WIDTH-1:0] diff;
    logic             q_bit;
    logic [WIDTH-1:0] rem_step;
    logic [WIDTH-1:0] dividend_orig;
    logic [WIDTH-1:0] rem_final;
    logic             sat;

    // Restoring-division step, divide-by-zero override and relation check.
    always_comb begin
        trial         = {rem_q, dvd_q[WIDTH-1]};
        dvs_ext       = {1'b0, dvs_q};
        q_bit         = (trial >= dvs_ext);
        // When the subtraction is taken the result is below the divisor,
        // so the low WIDTH bits of the difference are exact.
        diff          = trial[WIDTH-1:0] - dvs_q;
        rem_step      = q_bit ? diff : trial[WIDTH-1:0];
        dividend_orig = pos_q ? s_q : cand_q[WIDTH-1:0];
        rem_final     = (dvs_q == '0) ? dividend_orig : rem_step;
        sat           = 1'b0;
        unique case (rel_q)
            REL_SLE: sat = ($signed(rem_final) <= $signed(t_q));
            REL_SLT: sat = ($signed(rem_final) <  $signed(t_q));
            REL_ULE: sat = (rem_final <= t_q);
            REL_ULT: sat = (rem_final <  t_q);
        endcase
    end

    // Next-state and datapath register updates for the search FSM.
    always_comb begin
        // NOTE: every _d starts as its _q so no path through this block leaves
        // a signal unassigned, which would otherwise infer a latch.
        state_d   = state_q;
        s_d       = s_q;
        t_d       = t_q;
        rel_d     = rel_q;
        pos_d     = pos_q;
        cand_d    = cand_q;
        dvd_d     = dvd_q;
        dvs_d     = dvs_q;
        rem_d     = rem_q;
        step_d    = step_q;
        found_d   = found_q;
        x_d       = x_q;
        res_rem_d = res_rem_q;

        unique case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    s_d     = in_s;
                    t_d     = in_t;
                    rel_d   = rel_e'(in_rel);
                    pos_d   = in_pos;
                    cand_d  = '0;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                dvd_d   = pos_q ? s_q : cand_q[WIDTH-1:0];
                dvs_d   = pos_q ? cand_q[WIDTH-1:0] : s_q;
                rem_d   = '0;
                step_d  = '0;
                state_d = S_DIV;
            end
            S_DIV: begin
                rem_d  = rem_step;
                dvd_d  = {dvd_q[WIDTH-2:0], q_bit};
                step_d = step_q + CW'(1);
                if (step_q == LAST_STEP) begin
                    if (sat) begin
                        found_d   = 1'b1;
                        x_d       = cand_q[WIDTH-1:0];
                        res_rem_d = rem_final;
                        state_d   = S_DONE;
                    end else if (cand_q == LAST_CAND) begin
                        found_d   = 1'b0;
                        x_d       = '0;
                        res_rem_d = '0;
                        state_d   = S_DONE;
                    end else begin
                        cand_d  = cand_q + (WIDTH+1)'(1);
                        state_d = S_LOAD;
                    end
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
        endcase
    end

    // State and datapath registers; reset aborts any search in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            s_q       <= '0;
            t_q       <= '0;
            rel_q     <= REL_SLE;
            pos_q     <= 1'b0;
            cand_q    <= '0;
            dvd_q     <= '0;
            dvs_q     <= '0;
            rem_q     <= '0;
            step_q    <= '0;
            found_q   <= 1'b0;
            x_q       <= '0;
            res_rem_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // values from before this edge, independent of statement order.
            state_q   <= state_d;
            s_q       <= s_d;
            t_q       <= t_d;
            rel_q     <= rel_d;
            pos_q     <= pos_d;
            cand_q    <= cand_d;
            dvd_q     <= dvd_d;
            dvs_q     <= dvs_d;
            rem_q     <= rem_d;
            step_q    <= step_d;
            found_q   <= found_d;
            x_q       <= x_d;
            res_rem_q <= res_rem_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign out_found = found_q;
    assign out_x     = x_q;
    assign out_rem   = res_rem_q;

endmodule
